noc_inj_arb: RTL and testbench
==============================

Name: noc_inj_arb

Overview:
- Packet-aware round-robin arbiter sharing one NoC node injection port (request channel) between N_REQ local requesters.
- Per-requester outstanding-transaction limit; routes returning response packets back to the originating requester by tid index.
- Sits between local masters and one node's noc_req_i / noc_rsp_o of the mesh.

Parameters:
- N_REQ, 4, number of local requesters (>=2).
- TDATA_W, 32, stream data width.
- TID_W, 6, stream tid width; must be >= IDX_W.
- TDEST_W, 5, stream tdest width.
- TUSER_W, 5, stream tuser width.
- MAX_OUTS, 8, max outstanding request packets per requester (>=1).
- IDX_W, $clog2(N_REQ), derived requester-index width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  slave  axi4_stream_if[N_REQ]  local request streams (tvalid, tready, tdata, tid, tdest, tuser, tlast).
- noc_req_o  master  axi4_stream_if  merged request stream into the NoC.
- noc_rsp_i  slave  axi4_stream_if  response stream from the NoC.
- rsp_o  master  axi4_stream_if[N_REQ]  demultiplexed responses.
- busy_o  output  1  any outstanding count non-zero, or state LOCKED.
- err_o  output  1  sticky: orphan response seen.

Behaviour:
- Reset values: state IDLE, rr pointer 0, all outstanding counters 0, err_o 0, busy_o 0. While rst_n low: noc_req_o.tvalid, all rsp_o.tvalid, all req_i.tready, and noc_rsp_i.tready are 0.
- Eligible(k) = req_i[k].tvalid and cnt[k] < MAX_OUTS.
- IDLE: grant = first eligible index at or after rr pointer, wrapping. Zero-latency combinational forward: noc_req_o carries req_i[grant] fields; req_i[grant].tready = noc_req_o.tready; all other req_i tready are 0.
- tid rewrite: noc_req_o.tid[IDX_W-1:0] = grant; upper tid bits pass through. tdest, tuser, tdata, and tlast pass through unchanged.
- Beat accepted without tlast: go to LOCKED; grant is frozen. In LOCKED, the eligibility check is bypassed and only the frozen requester is forwarded.
- Beat accepted with tlast (in IDLE or LOCKED): cnt[grant]++, rr pointer = (grant+1) mod N_REQ, state IDLE. A single-beat packet stays in IDLE.
- No eligible requester in IDLE: noc_req_o.tvalid 0. The rr pointer is unchanged.
- Response routing: idx = noc_rsp_i.tid[IDX_W-1:0]. rsp_o[idx].tvalid = noc_rsp_i.tvalid. noc_rsp_i.tready = rsp_o[idx].tready. All rsp_o carry the noc_rsp_i fields unchanged.
- Response accepted with tlast: cnt[idx]--.
- Orphan response (idx >= N_REQ, or cnt[idx]==0 at the tlast beat): noc_rsp_i.tready forced 1, the beat is dropped (no rsp_o valid), err_o set until reset, counter untouched.
- Simultaneous request-tlast and response-tlast on the same index in one cycle: net counter change 0.
- Counter width is $clog2(MAX_OUTS+1). Counters never exceed MAX_OUTS: this is guaranteed by the eligibility rule.
- Reset mid-packet: state returns to IDLE. The partial packet is abandoned; the NoC side is reset concurrently.

Optional Feature:
- Macro NOC_INJ_ARB_OUTREG_EN.
- Defined: noc_req_o is driven through a full-throughput skid register slice (fwd+bwd registered). Request latency is 1 cycle. Arbitration and counters advance on the handshake at the slice input.
- Undefined: zero-latency combinational path as above.

Decomposition:
- Package noc_inj_arb_pkg: state enum (IDLE, LOCKED), idx-width and counter-width helper functions.
- Sub-module noc_rr_arb: mask-based round-robin priority selector with inputs (req vector, pointer) and outputs (one-hot grant, grant index). Purely combinational; the pointer register stays in noc_inj_arb.

Test Plan:
- Reqs 0..3 all valid with single-beat packets, noc_req_o.tready=1 → grants in order 0,1,2,3,0. Output tid[1:0] equals the grant index.
- Req1 sends a 4-beat packet while req2 is valid → req2 is held off for all 4 beats. Req2 is granted in the cycle after req1's tlast.
- MAX_OUTS=2, req0 sends 2 packets with no responses → req0.tready stays 0 and others are still served. One response with tid[1:0]=0 and tlast → req0 is eligible in the next cycle.
- Response with tid[1:0]=3 while rsp_o[3].tready=0 → noc_rsp_i.tready is 0 (backpressure). Release → the beat is delivered only on rsp_o[3].
- Response with tid[1:0]=2 while cnt[2]==0 → beat consumed, no rsp_o valid, err_o goes to 1 and stays 1.
- Assert rst_n low during beat 2 of a 3-beat packet → all valids 0 and counters 0. The next packet after reset is granted from requester 0.

Source files
------------

// File: rtl/noc_inj_arb_pkg.sv
// Shared types and width helpers for the NoC injection arbiter.
package noc_inj_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width for n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value m.
    function automatic int cnt_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/noc_rr_arb.sv
// Mask-based round-robin priority selector, purely combinational.
// Picks the first set request at or after ptr_i, wrapping to index 0.
module noc_rr_arb
    import noc_inj_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [N_REQ-1:0] mask;
    logic [N_REQ-1:0] masked;
    logic [N_REQ-1:0] cand;
    logic             found;

    // Masked requests win if any exist; otherwise wrap to the raw vector.
    always_comb begin
        mask      = '0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            mask[i] = (i >= 32'(ptr_i));
        end
        masked = req_i & mask;
        cand   = (|masked) ? masked : req_i;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (cand[i] && !found) begin
                gnt_o[i]  = 1'b1;
                gnt_idx_o = IDX_W'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_inj_arb.sv
// Packet-aware round-robin arbiter for one NoC node injection port, with
// per-requester outstanding limits and tid-indexed response routing.
// Optional macro NOC_INJ_ARB_OUTREG_EN: register the request output
// through a full-throughput skid slice (1-cycle latency).
module noc_inj_arb
    import noc_inj_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int TDATA_W  = 32,
    parameter int TID_W    = 6,
    parameter int TDEST_W  = 5,
    parameter int TUSER_W  = 5,
    parameter int MAX_OUTS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // local request streams
    input  logic [N_REQ-1:0]                req_i_tvalid,
    output logic [N_REQ-1:0]                req_i_tready,
    input  logic [N_REQ-1:0][TDATA_W-1:0]   req_i_tdata,
    input  logic [N_REQ-1:0][TID_W-1:0]     req_i_tid,
    input  logic [N_REQ-1:0][TDEST_W-1:0]   req_i_tdest,
    input  logic [N_REQ-1:0][TUSER_W-1:0]   req_i_tuser,
    input  logic [N_REQ-1:0]                req_i_tlast,
    // merged request stream into the NoC
    output logic                            noc_req_o_tvalid,
    input  logic                            noc_req_o_tready,
    output logic [TDATA_W-1:0]              noc_req_o_tdata,
    output logic [TID_W-1:0]                noc_req_o_tid,
    output logic [TDEST_W-1:0]              noc_req_o_tdest,
    output logic [TUSER_W-1:0]              noc_req_o_tuser,
    output logic                            noc_req_o_tlast,
    // response stream from the NoC
    input  logic                            noc_rsp_i_tvalid,
    output logic                            noc_rsp_i_tready,
    input  logic [TDATA_W-1:0]              noc_rsp_i_tdata,
    input  logic [TID_W-1:0]                noc_rsp_i_tid,
    input  logic [TDEST_W-1:0]              noc_rsp_i_tdest,
    input  logic [TUSER_W-1:0]              noc_rsp_i_tuser,
    input  logic                            noc_rsp_i_tlast,
    // demultiplexed responses
    output logic [N_REQ-1:0]                rsp_o_tvalid,
    input  logic [N_REQ-1:0]                rsp_o_tready,
    output logic [N_REQ-1:0][TDATA_W-1:0]   rsp_o_tdata,
    output logic [N_REQ-1:0][TID_W-1:0]     rsp_o_tid,
    output logic [N_REQ-1:0][TDEST_W-1:0]   rsp_o_tdest,
    output logic [N_REQ-1:0][TUSER_W-1:0]   rsp_o_tuser,
    output logic [N_REQ-1:0]                rsp_o_tlast,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = cnt_width(MAX_OUTS);

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             rr_q, rr_d;
    logic [IDX_W-1:0]             lock_q, lock_d;
    logic [N_REQ-1:0][CNT_W-1:0]  cnt_q;
    logic                         err_q;

    logic [N_REQ-1:0]             elig;
    logic [N_REQ-1:0]             arb_gnt;
    logic [IDX_W-1:0]             arb_idx;
    logic [IDX_W-1:0]             sel;
    logic                         sel_vld;

    // arbitration-side stream (input of the optional output slice)
    logic                         s_valid;
    logic                         s_ready;
    logic [TDATA_W-1:0]           s_tdata;
    logic [TID_W-1:0]             s_tid;
    logic [TDEST_W-1:0]           s_tdest;
    logic [TUSER_W-1:0]           s_tuser;
    logic                         s_tlast;
    logic                         req_done;

    logic [IDX_W-1:0]             rsp_idx;
    logic [N_REQ-1:0]             rsp_hit;
    logic                         orphan;
    logic                         rsp_done;

    // A requester is eligible when valid and below its outstanding limit.
    always_comb begin
        elig = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            elig[k] = req_i_tvalid[k] && (cnt_q[k] < CNT_W'(MAX_OUTS));
        end
    end

    noc_rr_arb #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i     (elig),
        .ptr_i     (rr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // Grant selection, request forwarding and next-state logic.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        lock_d       = lock_q;
        sel          = arb_idx;
        sel_vld      = |arb_gnt;
        if (state_q == LOCKED) begin
            sel     = lock_q;
            sel_vld = 1'b1;
        end
        s_valid      = rst_n && sel_vld && req_i_tvalid[sel];
        s_tdata      = req_i_tdata[sel];
        s_tid        = req_i_tid[sel];
        s_tid[IDX_W-1:0] = sel;
        s_tdest      = req_i_tdest[sel];
        s_tuser      = req_i_tuser[sel];
        s_tlast      = req_i_tlast[sel];
        req_i_tready = '0;
        if (rst_n && sel_vld) begin
            req_i_tready[sel] = s_ready;
        end
        req_done = 1'b0;
        if (s_valid && s_ready) begin
            if (s_tlast) begin
                req_done = 1'b1;
                state_d  = IDLE;
                rr_d     = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
            end else begin
                state_d  = LOCKED;
                lock_d   = sel;
            end
        end
    end

    // State, round-robin pointer and frozen grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            lock_q  <= lock_d;
        end
    end

    // Response routing. A response is an orphan when its index is out of
    // range or the owner has nothing outstanding; checked on every beat so
    // no part of an orphan packet leaks to a requester.
    assign rsp_idx = noc_rsp_i_tid[IDX_W-1:0];

    always_comb begin
        orphan  = 1'b1;
        rsp_hit = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rsp_hit[k] = (rsp_idx == IDX_W'(k));
            if (rsp_hit[k]) begin
                orphan = (cnt_q[k] == '0);
            end
        end
        rsp_o_tvalid     = rsp_hit & {N_REQ{rst_n && noc_rsp_i_tvalid && !orphan}};
        noc_rsp_i_tready = rst_n && (orphan || (|(rsp_hit & rsp_o_tready)));
        rsp_done         = noc_rsp_i_tvalid && noc_rsp_i_tready && noc_rsp_i_tlast && !orphan;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            rsp_o_tdata[k] = noc_rsp_i_tdata;
            rsp_o_tid[k]   = noc_rsp_i_tid;
            rsp_o_tdest[k] = noc_rsp_i_tdest;
            rsp_o_tuser[k] = noc_rsp_i_tuser;
            rsp_o_tlast[k] = noc_rsp_i_tlast;
        end
    end

    // Outstanding counters: +1 on request tlast, -1 on routed response tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (req_done && (sel == IDX_W'(k)) && !(rsp_done && rsp_hit[k])) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end else if (rsp_done && rsp_hit[k] && !(req_done && (sel == IDX_W'(k)))) begin
                    cnt_q[k] <= cnt_q[k] - 1'b1;
                end
            end
        end
    end

    // Sticky orphan flag; orphan beats are always accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (noc_rsp_i_tvalid && orphan) begin
            err_q <= 1'b1;
        end
    end

    assign err_o  = err_q;
    assign busy_o = (state_q == LOCKED) || (|cnt_q);

`ifdef NOC_INJ_ARB_OUTREG_EN
    localparam int PW = TDATA_W + TID_W + TDEST_W + TUSER_W + 1;

    logic [PW-1:0] s_pay, out_pay_q, skid_pay_q;
    logic          out_vld_q, skid_vld_q;

    assign s_pay   = {s_tdata, s_tid, s_tdest, s_tuser, s_tlast};
    assign s_ready = rst_n && !skid_vld_q;

    // Skid slice: the skid entry catches a beat accepted while the output stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            out_pay_q  <= '0;
            skid_pay_q <= '0;
        end else if (!out_vld_q || noc_req_o_tready) begin
            if (skid_vld_q) begin
                out_vld_q  <= 1'b1;
                out_pay_q  <= skid_pay_q;
                skid_vld_q <= 1'b0;
            end else begin
                out_vld_q  <= s_valid;
                out_pay_q  <= s_pay;
            end
        end else if (s_valid && s_ready) begin
            skid_vld_q <= 1'b1;
            skid_pay_q <= s_pay;
        end
    end

    assign noc_req_o_tvalid = rst_n && out_vld_q;
    assign {noc_req_o_tdata, noc_req_o_tid, noc_req_o_tdest,
            noc_req_o_tuser, noc_req_o_tlast} = out_pay_q;
`else
    assign s_ready          = rst_n && noc_req_o_tready;
    assign noc_req_o_tvalid = s_valid;
    assign noc_req_o_tdata  = s_tdata;
    assign noc_req_o_tid    = s_tid;
    assign noc_req_o_tdest  = s_tdest;
    assign noc_req_o_tuser  = s_tuser;
    assign noc_req_o_tlast  = s_tlast;
`endif

endmodule

// File: tb/tb_noc_inj_arb.sv
// Directed bench for noc_inj_arb (default build, MAX_OUTS=2).
module tb_noc_inj_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int DSW = 5;
    localparam int UW = 5;

    logic clk, rst_n;
    logic [N-1:0]          req_tvalid, req_tready, req_tlast;
    logic [N-1:0][DW-1:0]  req_tdata;
    logic [N-1:0][TW-1:0]  req_tid;
    logic [N-1:0][DSW-1:0] req_tdest;
    logic [N-1:0][UW-1:0]  req_tuser;
    logic                  nq_tvalid, nq_tready, nq_tlast;
    logic [DW-1:0]         nq_tdata;
    logic [TW-1:0]         nq_tid;
    logic [DSW-1:0]        nq_tdest;
    logic [UW-1:0]         nq_tuser;
    logic                  nr_tvalid, nr_tready, nr_tlast;
    logic [DW-1:0]         nr_tdata;
    logic [TW-1:0]         nr_tid;
    logic [DSW-1:0]        nr_tdest;
    logic [UW-1:0]         nr_tuser;
    logic [N-1:0]          ro_tvalid, ro_tready, ro_tlast;
    logic [N-1:0][DW-1:0]  ro_tdata;
    logic [N-1:0][TW-1:0]  ro_tid;
    logic [N-1:0][DSW-1:0] ro_tdest;
    logic [N-1:0][UW-1:0]  ro_tuser;
    logic                  busy, err;

    int total = 0;
    int bad   = 0;

    noc_inj_arb #(
        .N_REQ    (N),
        .TDATA_W  (DW),
        .TID_W    (TW),
        .TDEST_W  (DSW),
        .TUSER_W  (UW),
        .MAX_OUTS (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i_tvalid     (req_tvalid),
        .req_i_tready     (req_tready),
        .req_i_tdata      (req_tdata),
        .req_i_tid        (req_tid),
        .req_i_tdest      (req_tdest),
        .req_i_tuser      (req_tuser),
        .req_i_tlast      (req_tlast),
        .noc_req_o_tvalid (nq_tvalid),
        .noc_req_o_tready (nq_tready),
        .noc_req_o_tdata  (nq_tdata),
        .noc_req_o_tid    (nq_tid),
        .noc_req_o_tdest  (nq_tdest),
        .noc_req_o_tuser  (nq_tuser),
        .noc_req_o_tlast  (nq_tlast),
        .noc_rsp_i_tvalid (nr_tvalid),
        .noc_rsp_i_tready (nr_tready),
        .noc_rsp_i_tdata  (nr_tdata),
        .noc_rsp_i_tid    (nr_tid),
        .noc_rsp_i_tdest  (nr_tdest),
        .noc_rsp_i_tuser  (nr_tuser),
        .noc_rsp_i_tlast  (nr_tlast),
        .rsp_o_tvalid     (ro_tvalid),
        .rsp_o_tready     (ro_tready),
        .rsp_o_tdata      (ro_tdata),
        .rsp_o_tid        (ro_tid),
        .rsp_o_tdest      (ro_tdest),
        .rsp_o_tuser      (ro_tuser),
        .rsp_o_tlast      (ro_tlast),
        .busy_o           (busy),
        .err_o            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock, land 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic last, input logic [31:0] d);
        req_tvalid[k] = v;
        req_tlast[k]  = last;
        req_tdata[k]  = d;
    endtask

    task automatic set_rsp(input logic v, input logic [5:0] tid, input logic [31:0] d);
        nr_tvalid = v;
        nr_tid    = tid;
        nr_tdata  = d;
        nr_tlast  = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        nq_tready = 1'b1;
        ro_tready = 4'b1111;
        nr_tdest  = 5'h07;
        nr_tuser  = 5'h09;
        for (int k = 0; k < N; k++) begin
            req_tid[k]   = 6'b101011;
            req_tdest[k] = 5'(k + 3);
            req_tuser[k] = 5'h11;
            set_req(k, 1'b1, 1'b1, 32'h100 + 32'(k));
        end
        set_rsp(1'b1, 6'd0, 32'h0);
        #2;
        chk("rst_nq_tvalid", nq_tvalid, 0);
        chk("rst_req_tready", req_tready, 0);
        chk("rst_nr_tready", nr_tready, 0);
        chk("rst_ro_tvalid", ro_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        nr_tvalid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // round robin over single-beat packets: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            int g;
            g = i % 4;
            #2;
            chk("rr_tvalid", nq_tvalid, 1);
            chk("rr_tready", req_tready, 4'b0001 << g);
            chk("rr_tid", nq_tid, 6'h28 | 6'(g));
            chk("rr_tdata", nq_tdata, 32'h100 + 32'(g));
            chk("rr_tdest", nq_tdest, 5'(g + 3));
            tick();
        end
        // cnt = {0:2,1:1,2:1,3:1}, rr=1
        #2;
        chk("busy_after_rr", busy, 1);

        // req0 at limit, req3 served
        set_req(1, 1'b0, 1'b1, 32'h101);
        set_req(2, 1'b0, 1'b1, 32'h102);
        #2;
        chk("lim_tready_r3", req_tready, 4'b1000);
        chk("lim_tid_r3", nq_tid, 6'h2B);
        tick();
        set_req(3, 1'b0, 1'b1, 32'h103);
        set_rsp(1'b1, 6'b110000, 32'hABCD);
        #2;
        chk("lim_nq_tvalid", nq_tvalid, 0);
        chk("lim_tready_none", req_tready, 4'b0000);
        chk("rsp0_ro_tvalid", ro_tvalid, 4'b0001);
        chk("rsp0_nr_tready", nr_tready, 1);
        chk("rsp0_tdata", ro_tdata[0], 32'hABCD);
        chk("rsp0_tid", ro_tid[0], 6'h30);
        tick();
        // cnt0=1: req0 eligible again; simultaneous response for idx 0
        #2;
        chk("req0_again", req_tready, 4'b0001);
        chk("sim_ro_tvalid", ro_tvalid, 4'b0001);
        tick();
        // net zero: cnt0 still 1
        nr_tvalid = 1'b0;
        #2;
        chk("net0_grant", req_tready, 4'b0001);
        tick();
        #2;
        chk("net0_full", nq_tvalid, 0);
        set_req(0, 1'b0, 1'b1, 32'h100);

        // backpressure on rsp_o[3]
        set_rsp(1'b1, 6'd3, 32'h3333);
        ro_tready = 4'b0111;
        #2;
        chk("bp_nr_tready", nr_tready, 0);
        chk("bp_ro_tvalid", ro_tvalid, 4'b1000);
        tick();
        ro_tready = 4'b1111;
        #2;
        chk("bp_rel_nr_tready", nr_tready, 1);
        chk("bp_rel_ro_tvalid", ro_tvalid, 4'b1000);
        tick();
        set_rsp(1'b1, 6'd1, 32'h1111);
        #2;
        chk("rsp1_ro_tvalid", ro_tvalid, 4'b0010);
        tick();
        set_rsp(1'b1, 6'd2, 32'h2222);
        #2;
        chk("rsp2_ro_tvalid", ro_tvalid, 4'b0100);
        tick();

        // orphan: cnt2 == 0
        ro_tready = 4'b0000;
        #2;
        chk("orph_nr_tready", nr_tready, 1);
        chk("orph_ro_tvalid", ro_tvalid, 4'b0000);
        chk("orph_err_before", err, 0);
        tick();
        nr_tvalid = 1'b0;
        ro_tready = 4'b1111;
        #2;
        chk("orph_err_set", err, 1);
        tick();
        #2;
        chk("orph_err_sticky", err, 1);

        // locked 4-beat packet from req1, req2 waiting (rr=1)
        set_req(1, 1'b1, 1'b0, 32'h200);
        set_req(2, 1'b1, 1'b1, 32'h300);
        #2;
        chk("lk_b1_tready", req_tready, 4'b0010);
        chk("lk_b1_tdata", nq_tdata, 32'h200);
        chk("lk_b1_tlast", nq_tlast, 0);
        tick();
        req_tvalid[1] = 1'b0;
        #2;
        chk("lk_gap_tvalid", nq_tvalid, 0);
        chk("lk_gap_tready", req_tready, 4'b0010);
        chk("lk_busy", busy, 1);
        tick();
        set_req(1, 1'b1, 1'b0, 32'h201);
        #2;
        chk("lk_b2_tready", req_tready, 4'b0010);
        chk("lk_b2_tdata", nq_tdata, 32'h201);
        tick();
        set_req(1, 1'b1, 1'b0, 32'h202);
        nq_tready = 1'b0;
        #2;
        chk("lk_stall_tready", req_tready, 4'b0000);
        chk("lk_stall_tvalid", nq_tvalid, 1);
        tick();
        nq_tready = 1'b1;
        #2;
        chk("lk_b3_tdata", nq_tdata, 32'h202);
        tick();
        set_req(1, 1'b1, 1'b1, 32'h203);
        #2;
        chk("lk_b4_tready", req_tready, 4'b0010);
        chk("lk_b4_tlast", nq_tlast, 1);
        tick();
        set_req(1, 1'b0, 1'b1, 32'h203);
        #2;
        chk("lk_next_r2", req_tready, 4'b0100);
        chk("lk_next_tdata", nq_tdata, 32'h300);
        chk("lk_next_tid", nq_tid, 6'h2A);
        tick();
        set_req(2, 1'b0, 1'b1, 32'h300);

        // reset during beat 2 of a 3-beat packet from req3 (rr=3)
        set_req(3, 1'b1, 1'b0, 32'h400);
        #2;
        chk("rm_b1_tready", req_tready, 4'b1000);
        tick();
        set_req(3, 1'b1, 1'b0, 32'h401);
        set_rsp(1'b1, 6'd1, 32'h5555);
        rst_n = 1'b0;
        #2;
        chk("rm_nq_tvalid", nq_tvalid, 0);
        chk("rm_req_tready", req_tready, 0);
        chk("rm_nr_tready", nr_tready, 0);
        chk("rm_ro_tvalid", ro_tvalid, 0);
        chk("rm_busy", busy, 0);
        chk("rm_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        nr_tvalid = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 1'b1, 32'h100 + 32'(k));
        #2;
        chk("post_rst_grant0", req_tready, 4'b0001);
        chk("post_rst_tid", nq_tid, 6'h28);
        chk("post_rst_busy", busy, 0);
        tick();
        for (int k = 1; k < N; k++) req_tvalid[k] = 1'b0;
        #2;
        chk("post_rst_cnt0_a", req_tready, 4'b0001);
        tick();
        #2;
        chk("post_rst_cnt0_full", nq_tvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
